vend_ctrl_multi: RTL and testbench

//  Parametrised multi-item vending controller. Accumulates coins against the price of a

---
 rtl/vend_ctrl_multi.sv | 204 ++++++++++++++++++++
 tb/tb_vend_ctrl_multi.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/vend_ctrl_multi.sv
// Multi-item vending controller: coin credit, dispense with change, refund, restock and price programming.
// Optional COLLECT inactivity auto-refund is compiled in when VEND_TIMEOUT_EN is defined.
module vend_ctrl_multi #(
  parameter int NUM_ITEMS     = 4,
  parameter int ITEM_W        = 2,
  parameter int MONEY_W       = 8,
  parameter int STOCK_W       = 4,
  parameter int PRICE_DEFAULT = 20,
  parameter int TIMEOUT_CYC   = 1000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [ITEM_W-1:0]  item_sel,
  input  logic               coin_valid,
  input  logic [MONEY_W-1:0] coin_value,
  input  logic               cancel,
  input  logic               restock_valid,
  input  logic [ITEM_W-1:0]  restock_item,
  input  logic [STOCK_W-1:0] restock_qty,
  input  logic               price_wr,
  input  logic [ITEM_W-1:0]  price_item,
  input  logic [MONEY_W-1:0] price_data,
  output logic               dispense,
  output logic [ITEM_W-1:0]  dispense_item,
  output logic               change_valid,
  output logic [MONEY_W-1:0] change_amt,
  output logic               coin_reject,
  output logic [MONEY_W-1:0] money_needed,
  output logic [STOCK_W-1:0] stock_level,
  output logic               busy
);

  if (NUM_ITEMS < 2 || (2 ** ITEM_W) < NUM_ITEMS || TIMEOUT_CYC < 1) begin : g_param_check
    $error("vend_ctrl_multi: invalid parameter set");
  end

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_VEND    = 2'd2,
    S_REFUND  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [MONEY_W-1:0] credit_q, credit_d;
  logic [ITEM_W-1:0]  sel_q, sel_d;
  logic [MONEY_W-1:0] chg_q, chg_d;
  logic               reject_q, reject_d;

  logic [MONEY_W-1:0] price_q [NUM_ITEMS];
  logic [MONEY_W-1:0] price_d [NUM_ITEMS];
  logic [STOCK_W-1:0] stock_q [NUM_ITEMS];
  logic [STOCK_W-1:0] stock_d [NUM_ITEMS];

  logic               coin_nz;
  logic [MONEY_W:0]   coin_sum;
  logic               coin_fits;
  logic               coin_accept;
  logic [MONEY_W-1:0] price_sel;
  logic [MONEY_W-1:0] vend_chg;

  assign coin_nz     = coin_valid && (coin_value != '0);
  assign coin_sum    = {1'b0, credit_q} + {1'b0, coin_value};
  assign coin_fits   = !coin_sum[MONEY_W];
  assign coin_accept = coin_nz && coin_fits;
  assign price_sel   = price_q[sel_q];
  assign vend_chg    = credit_q - price_sel;

`ifdef VEND_TIMEOUT_EN
  localparam int TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
  logic [TMO_W-1:0] tmo_q, tmo_d;
`endif

  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    sel_d    = sel_q;
    chg_d    = chg_q;
    reject_d = 1'b0;
`ifdef VEND_TIMEOUT_EN
    tmo_d    = tmo_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (coin_nz) begin
          sel_d    = item_sel;
          credit_d = coin_value;
          state_d  = (stock_q[item_sel] == '0) ? S_REFUND : S_COLLECT;
`ifdef VEND_TIMEOUT_EN
          tmo_d    = '0;
`endif
        end
      end
      S_COLLECT: begin
        if (coin_nz && !coin_fits) begin
          reject_d = 1'b1;
        end
        if (coin_accept) begin
          credit_d = coin_sum[MONEY_W-1:0];
        end
        // Compare against the updated credit so dispense follows the paying coin by one cycle.
        if (cancel) begin
          state_d = S_REFUND;
        end else if (credit_d >= price_sel) begin
          state_d = S_VEND;
`ifdef VEND_TIMEOUT_EN
        end else if (!coin_accept && tmo_q == TMO_LAST) begin
          state_d = S_REFUND;
`endif
        end
`ifdef VEND_TIMEOUT_EN
        tmo_d = coin_accept ? '0 : tmo_q + 1'b1;
`endif
      end
      S_VEND: begin
        reject_d = coin_nz;
        chg_d    = vend_chg;
        credit_d = '0;
        state_d  = S_IDLE;
      end
      S_REFUND: begin
        reject_d = coin_nz;
        chg_d    = credit_q;
        credit_d = '0;
        state_d  = S_IDLE;
      end
      default: begin
        state_d  = S_IDLE;
        credit_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      credit_q <= '0;
      sel_q    <= '0;
      chg_q    <= '0;
      reject_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      sel_q    <= sel_d;
      chg_q    <= chg_d;
      reject_q <= reject_d;
    end
  end

`ifdef VEND_TIMEOUT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_d;
    end
  end
`endif

  // Per-slot restock (saturating) and vend decrement; prices only change while idle.
  for (genvar gi = 0; gi < NUM_ITEMS; gi++) begin : g_item
    logic               restock_hit;
    logic               vend_hit;
    logic               price_hit;
    logic [STOCK_W-1:0] add_qty;
    logic [STOCK_W:0]   stock_sum;
    logic [STOCK_W-1:0] stock_sat;

    assign restock_hit = restock_valid && (restock_item == ITEM_W'(gi));
    assign vend_hit    = (state_q == S_VEND) && (sel_q == ITEM_W'(gi));
    assign price_hit   = price_wr && (state_q == S_IDLE) && (price_item == ITEM_W'(gi));
    assign add_qty     = restock_hit ? restock_qty : '0;
    assign stock_sum   = {1'b0, stock_q[gi]} + {1'b0, add_qty};
    assign stock_sat   = stock_sum[STOCK_W] ? '1 : stock_sum[STOCK_W-1:0];
    assign stock_d[gi] = (vend_hit && stock_sat != '0) ? stock_sat - 1'b1 : stock_sat;
    assign price_d[gi] = price_hit ? price_data : price_q[gi];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_ITEMS; i++) begin
        stock_q[i] <= '0;
        price_q[i] <= MONEY_W'(PRICE_DEFAULT);
      end
    end else begin
      for (int i = 0; i < NUM_ITEMS; i++) begin
        stock_q[i] <= stock_d[i];
        price_q[i] <= price_d[i];
      end
    end
  end

  assign dispense      = (state_q == S_VEND);
  assign dispense_item = sel_q;
  assign change_valid  = (state_q == S_VEND) || (state_q == S_REFUND);
  assign change_amt    = (state_q == S_VEND)   ? vend_chg :
                         (state_q == S_REFUND) ? credit_q : chg_q;
  assign coin_reject   = reject_q;
  assign money_needed  = (state_q == S_COLLECT && price_sel > credit_q) ? price_sel - credit_q : '0;
  assign stock_level   = stock_q[item_sel];
  assign busy          = (state_q != S_IDLE);

endmodule

// File: tb/tb_vend_ctrl_multi.sv
// Directed self-checking bench for vend_ctrl_multi; inputs change and outputs are sampled on the falling edge.
module tb_vend_ctrl_multi;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] item_sel;
  logic       coin_valid;
  logic [7:0] coin_value;
  logic       cancel;
  logic       restock_valid;
  logic [1:0] restock_item;
  logic [3:0] restock_qty;
  logic       price_wr;
  logic [1:0] price_item;
  logic [7:0] price_data;
  logic       dispense;
  logic [1:0] dispense_item;
  logic       change_valid;
  logic [7:0] change_amt;
  logic       coin_reject;
  logic [7:0] money_needed;
  logic [3:0] stock_level;
  logic       busy;

  int n_cmp = 0;
  int n_bad = 0;

  vend_ctrl_multi #(
    .NUM_ITEMS(4), .ITEM_W(2), .MONEY_W(8), .STOCK_W(4),
    .PRICE_DEFAULT(20), .TIMEOUT_CYC(8)
  ) dut (
    .clk(clk), .reset(reset), .item_sel(item_sel),
    .coin_valid(coin_valid), .coin_value(coin_value), .cancel(cancel),
    .restock_valid(restock_valid), .restock_item(restock_item), .restock_qty(restock_qty),
    .price_wr(price_wr), .price_item(price_item), .price_data(price_data),
    .dispense(dispense), .dispense_item(dispense_item),
    .change_valid(change_valid), .change_amt(change_amt),
    .coin_reject(coin_reject), .money_needed(money_needed),
    .stock_level(stock_level), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    reset = 1'b1; item_sel = 2'd0; coin_valid = 1'b0; coin_value = 8'd0; cancel = 1'b0;
    restock_valid = 1'b0; restock_item = 2'd0; restock_qty = 4'd0;
    price_wr = 1'b0; price_item = 2'd0; price_data = 8'd0;
    repeat (3) @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (dispense !== 1'b0) begin n_bad++; $display("FAIL reset_dispense: got %b want 0", dispense); end
    n_cmp++; if (change_valid !== 1'b0) begin n_bad++; $display("FAIL reset_change_valid: got %b want 0", change_valid); end
    n_cmp++; if (change_amt !== 8'd0) begin n_bad++; $display("FAIL reset_change_amt: got %0d want 0", change_amt); end
    n_cmp++; if (coin_reject !== 1'b0) begin n_bad++; $display("FAIL reset_coin_reject: got %b want 0", coin_reject); end
    n_cmp++; if (stock_level !== 4'd0) begin n_bad++; $display("FAIL reset_stock: got %0d want 0", stock_level); end
    reset = 1'b0;
    // Zero-value coin and cancel in IDLE must both be ignored.
    coin_valid = 1'b1; coin_value = 8'd0; cancel = 1'b1;
    @(negedge clk); coin_valid = 1'b0; cancel = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL idle_ignore_busy: got %b want 0", busy); end
    n_cmp++; if (change_valid !== 1'b0) begin n_bad++; $display("FAIL idle_ignore_change: got %b want 0", change_valid); end
    $display("txn reset: busy=%b change_amt=%0d", busy, change_amt);
  endtask

  task automatic test_default_price();
    restock_valid = 1'b1; restock_item = 2'd0; restock_qty = 4'd5; item_sel = 2'd0;
    @(negedge clk); restock_valid = 1'b0;
    n_cmp++; if (stock_level !== 4'd5) begin n_bad++; $display("FAIL dflt_stock: got %0d want 5", stock_level); end
    coin_valid = 1'b1; coin_value = 8'd5;
    @(negedge clk); coin_valid = 1'b0;
    n_cmp++; if (money_needed !== 8'd15) begin n_bad++; $display("FAIL dflt_needed: got %0d want 15", money_needed); end
    cancel = 1'b1;
    @(negedge clk); cancel = 1'b0;
    n_cmp++; if (change_valid !== 1'b1 || change_amt !== 8'd5 || dispense !== 1'b0) begin
      n_bad++; $display("FAIL dflt_refund: got cv=%b amt=%0d disp=%b want cv=1 amt=5 disp=0", change_valid, change_amt, dispense); end
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0 || change_valid !== 1'b0 || change_amt !== 8'd5) begin
      n_bad++; $display("FAIL dflt_hold: got busy=%b cv=%b amt=%0d want busy=0 cv=0 amt=5", busy, change_valid, change_amt); end
    $display("txn default_price: refund 5");
  endtask

  task automatic test_purchase();
    restock_valid = 1'b1; restock_item = 2'd1; restock_qty = 4'd3;
    price_wr = 1'b1; price_item = 2'd1; price_data = 8'd35; item_sel = 2'd1;
    @(negedge clk); restock_valid = 1'b0; price_wr = 1'b0;
    n_cmp++; if (stock_level !== 4'd3) begin n_bad++; $display("FAIL t1_stock_init: got %0d want 3", stock_level); end
    coin_valid = 1'b1; coin_value = 8'd20;
    @(negedge clk); coin_valid = 1'b0;
    n_cmp++; if (money_needed !== 8'd15) begin n_bad++; $display("FAIL t1_needed: got %0d want 15", money_needed); end
    coin_valid = 1'b1; coin_value = 8'd20;
    @(negedge clk); coin_valid = 1'b0;
    n_cmp++; if (dispense !== 1'b1 || dispense_item !== 2'd1) begin
      n_bad++; $display("FAIL t1_dispense: got disp=%b item=%0d want 1 item 1", dispense, dispense_item); end
    n_cmp++; if (change_valid !== 1'b1 || change_amt !== 8'd5) begin
      n_bad++; $display("FAIL t1_change: got cv=%b amt=%0d want cv=1 amt=5", change_valid, change_amt); end
    @(negedge clk);
    n_cmp++; if (dispense !== 1'b0 || stock_level !== 4'd2 || busy !== 1'b0) begin
      n_bad++; $display("FAIL t1_after: got disp=%b stock=%0d busy=%b want 0 2 0", dispense, stock_level, busy); end
    $display("txn purchase: item 1 change %0d stock %0d", change_amt, stock_level);
  endtask

  task automatic test_cancel();
    restock_valid = 1'b1; restock_item = 2'd2; restock_qty = 4'd4;
    price_wr = 1'b1; price_item = 2'd2; price_data = 8'd50; item_sel = 2'd2;
    @(negedge clk); restock_valid = 1'b0; price_wr = 1'b0;
    coin_valid = 1'b1; coin_value = 8'd20;
    @(negedge clk); coin_valid = 1'b0;
    n_cmp++; if (money_needed !== 8'd30) begin n_bad++; $display("FAIL t2_needed: got %0d want 30", money_needed); end
    price_wr = 1'b1; price_item = 2'd2; price_data = 8'd10;
    @(negedge clk); price_wr = 1'b0;
    n_cmp++; if (money_needed !== 8'd30 || busy !== 1'b1) begin
      n_bad++; $display("FAIL t2_price_blocked: got needed=%0d busy=%b want 30 1", money_needed, busy); end
    cancel = 1'b1;
    @(negedge clk); cancel = 1'b0;
    n_cmp++; if (change_valid !== 1'b1 || change_amt !== 8'd20 || dispense !== 1'b0) begin
      n_bad++; $display("FAIL t2_refund: got cv=%b amt=%0d disp=%b want 1 20 0", change_valid, change_amt, dispense); end
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL t2_idle: got busy=%b want 0", busy); end
    $display("txn cancel: refund %0d", change_amt);
  endtask

  task automatic test_sold_out();
    item_sel = 2'd3; coin_valid = 1'b1; coin_value = 8'd25;
    @(negedge clk); coin_valid = 1'b0;
    n_cmp++; if (change_valid !== 1'b1 || change_amt !== 8'd25 || dispense !== 1'b0) begin
      n_bad++; $display("FAIL t3_refund: got cv=%b amt=%0d disp=%b want 1 25 0", change_valid, change_amt, dispense); end
    n_cmp++; if (stock_level !== 4'd0) begin n_bad++; $display("FAIL t3_stock: got %0d want 0", stock_level); end
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL t3_idle: got busy=%b want 0", busy); end
    $display("txn sold_out: refund 25");
  endtask

  task automatic test_overflow();
    price_wr = 1'b1; price_item = 2'd1; price_data = 8'd255; item_sel = 2'd1;
    @(negedge clk); price_wr = 1'b0;
    coin_valid = 1'b1; coin_value = 8'd250;
    @(negedge clk); coin_valid = 1'b0;
    n_cmp++; if (money_needed !== 8'd5) begin n_bad++; $display("FAIL t4_needed: got %0d want 5", money_needed); end
    coin_valid = 1'b1; coin_value = 8'd10;
    @(negedge clk); coin_valid = 1'b0;
    n_cmp++; if (coin_reject !== 1'b1 || money_needed !== 8'd5 || busy !== 1'b1) begin
      n_bad++; $display("FAIL t4_reject: got rej=%b needed=%0d busy=%b want 1 5 1", coin_reject, money_needed, busy); end
    coin_valid = 1'b1; coin_value = 8'd5;
    @(negedge clk); coin_valid = 1'b0;
    n_cmp++; if (coin_reject !== 1'b0 || dispense !== 1'b1 || change_amt !== 8'd0 || change_valid !== 1'b1) begin
      n_bad++; $display("FAIL t4_vend: got rej=%b disp=%b amt=%0d cv=%b want 0 1 0 1", coin_reject, dispense, change_amt, change_valid); end
    coin_valid = 1'b1; coin_value = 8'd7;
    @(negedge clk); coin_valid = 1'b0;
    n_cmp++; if (coin_reject !== 1'b1 || busy !== 1'b0 || stock_level !== 4'd1) begin
      n_bad++; $display("FAIL t4_vend_coin: got rej=%b busy=%b stock=%0d want 1 0 1", coin_reject, busy, stock_level); end
    @(negedge clk);
    n_cmp++; if (coin_reject !== 1'b0) begin n_bad++; $display("FAIL t4_reject_pulse: got %b want 0", coin_reject); end
    $display("txn overflow: reject then exact vend");
  endtask

  task automatic test_restock();
    item_sel = 2'd0; coin_valid = 1'b1; coin_value = 8'd20;
    @(negedge clk); coin_valid = 1'b0;
    n_cmp++; if (busy !== 1'b1 || dispense !== 1'b0) begin
      n_bad++; $display("FAIL t5_collect: got busy=%b disp=%b want 1 0", busy, dispense); end
    @(negedge clk);
    n_cmp++; if (dispense !== 1'b1 || change_amt !== 8'd0) begin
      n_bad++; $display("FAIL t5_vend: got disp=%b amt=%0d want 1 0", dispense, change_amt); end
    restock_valid = 1'b1; restock_item = 2'd0; restock_qty = 4'd2;
    @(negedge clk); restock_valid = 1'b0;
    n_cmp++; if (stock_level !== 4'd6) begin n_bad++; $display("FAIL t5_vend_restock: got %0d want 6", stock_level); end
    restock_valid = 1'b1; restock_qty = 4'd8;
    @(negedge clk); restock_valid = 1'b0;
    n_cmp++; if (stock_level !== 4'd14) begin n_bad++; $display("FAIL t5_restock14: got %0d want 14", stock_level); end
    restock_valid = 1'b1; restock_qty = 4'd15;
    @(negedge clk); restock_valid = 1'b0;
    n_cmp++; if (stock_level !== 4'd15) begin n_bad++; $display("FAIL t5_saturate: got %0d want 15", stock_level); end
    $display("txn restock: stock %0d", stock_level);
  endtask

  task automatic test_timeout();
    int waited;
    logic got;
    waited = 0; got = 1'b0;
    item_sel = 2'd0; coin_valid = 1'b1; coin_value = 8'd10;
    @(negedge clk); coin_valid = 1'b0;
    while (!got && waited < 20) begin
      @(negedge clk);
      waited++;
      if (change_valid === 1'b1) got = 1'b1;
    end
`ifdef VEND_TIMEOUT_EN
    n_cmp++; if (got !== 1'b1 || waited != 8) begin
      n_bad++; $display("FAIL t6_timeout: got refund=%b after %0d want 1 after 8", got, waited); end
    n_cmp++; if (change_amt !== 8'd10 || dispense !== 1'b0) begin
      n_bad++; $display("FAIL t6_amt: got amt=%0d disp=%b want 10 0", change_amt, dispense); end
`else
    n_cmp++; if (got !== 1'b0 || busy !== 1'b1) begin
      n_bad++; $display("FAIL t6_no_timeout: got refund=%b busy=%b want 0 1", got, busy); end
    cancel = 1'b1;
    @(negedge clk); cancel = 1'b0;
    n_cmp++; if (change_valid !== 1'b1 || change_amt !== 8'd10) begin
      n_bad++; $display("FAIL t6_cancel: got cv=%b amt=%0d want 1 10", change_valid, change_amt); end
`endif
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL t6_idle: got busy=%b want 0", busy); end
    $display("txn timeout: waited %0d refund %0d", waited, change_amt);
  endtask

  initial begin
    test_reset();
    test_default_price();
    test_purchase();
    test_cancel();
    test_sold_out();
    test_overflow();
    test_restock();
    test_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
